// File: rtl/ball_engine.sv
// Pong-style ball engine: steps the ball once per frame, bounces it off the walls and the paddle,
// handles ball loss with a timed hold, and produces a registered per-pixel "ball here" flag.
module ball_engine #(
   parameter int BALL_SIZE   = 8,
   parameter int LEFT_EDGE   = 8,
   parameter int RIGHT_EDGE  = 632,
   parameter int TOP_EDGE    = 8,
   parameter int PADDLE_TOP  = 460,
   parameter int PADDLE_HALF = 32,
   parameter int LOSE_Y      = 472,
   parameter int LOST_FRAMES = 60
) (
   input  logic       pxl_clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       serve,
   input  logic [9:0] paddle_x,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       ball_on,
   output logic       lose,
   output logic       bounce,
   output logic [1:0] state
);
   typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, LOST = 2'b10} state_t;

   localparam logic [10:0] SIZE_W  = 11'(BALL_SIZE);
   localparam logic [10:0] LEFT_W  = 11'(LEFT_EDGE);
   localparam logic [10:0] RIGHT_W = 11'(RIGHT_EDGE);
   localparam logic [10:0] TOP_W   = 11'(TOP_EDGE);
   localparam logic [10:0] PTOP_W  = 11'(PADDLE_TOP);
   localparam logic [10:0] HALF_W  = 11'(PADDLE_HALF);
   localparam logic [10:0] LOSE_W  = 11'(LOSE_Y);
   localparam logic [5:0]  LOST_LAST = 6'(LOST_FRAMES - 1);
   localparam logic [9:0]  HOME_X  = 10'd320;
   localparam logic [9:0]  HOME_Y  = 10'd240;

   state_t     state_q, state_d;
   logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic       dx_q, dx_d, dy_q, dy_d;   // 1 = right / down
   logic       lose_q, lose_d, bounce_q, bounce_d, ball_on_q, ball_on_d;
   logic [5:0] lost_cnt_q, lost_cnt_d;

   logic [10:0] bx, by, bx_end, by_end, px, pad_lo, pad_hi, hc, vc;
   logic        overlap, flip_x, flip_y, dx_new, dy_new;

   // Collision geometry, widened to 11 bits so sums never wrap and the paddle's left end clamps at 0.
   always_comb begin
      bx      = {1'b0, ball_x_q};
      by      = {1'b0, ball_y_q};
      bx_end  = bx + SIZE_W;
      by_end  = by + SIZE_W;
      px      = {1'b0, paddle_x};
      hc      = {1'b0, hcount};
      vc      = {1'b0, vcount};
      pad_lo  = (px > HALF_W) ? (px - HALF_W) : 11'd0;
      pad_hi  = px + HALF_W;
      overlap = (bx_end > pad_lo) && (bx < pad_hi);
      flip_x  = dx_q ? (bx_end >= RIGHT_W) : (bx <= LEFT_W);
      flip_y  = dy_q ? ((by_end >= PTOP_W) && (by_end < PTOP_W + 11'd4) && overlap)
                     : (by <= TOP_W);
      dx_new  = dx_q ^ flip_x;
      dy_new  = dy_q ^ flip_y;
   end

   always_comb begin
      state_d    = state_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      bounce_d   = 1'b0;
      lost_cnt_d = lost_cnt_q;
      case (state_q)
         IDLE: begin
            lost_cnt_d = 6'd0;
            if (serve) begin
               state_d = PLAY;
               dx_d    = 1'b1;
               dy_d    = 1'b1;
            end
         end
         PLAY: begin
            if (frame_tick) begin
               if (by >= LOSE_W) begin
                  state_d = LOST;
               end else begin
                  dx_d     = dx_new;
                  dy_d     = dy_new;
                  bounce_d = flip_x | flip_y;
                  ball_x_d = dx_new ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
                  ball_y_d = dy_new ? ball_y_q + 10'd2 : ball_y_q - 10'd2;
               end
            end
         end
         LOST: begin
            if (frame_tick) begin
               if (lost_cnt_q == LOST_LAST) begin
                  state_d    = IDLE;
                  lost_cnt_d = 6'd0;
                  ball_x_d   = HOME_X;
                  ball_y_d   = HOME_Y;
                  dx_d       = 1'b1;
                  dy_d       = 1'b1;
               end else begin
                  lost_cnt_d = lost_cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            lost_cnt_d = 6'd0;
         end
      endcase
      lose_d    = (state_d == LOST);
      ball_on_d = ((state_q == IDLE) || (state_q == PLAY)) &&
                  (hcount < 10'd640) && (vcount < 10'd480) &&
                  (hc >= bx) && (hc < bx_end) && (vc >= by) && (vc < by_end);
   end

   always_ff @(posedge pxl_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ball_x_q   <= HOME_X;
         ball_y_q   <= HOME_Y;
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
         lose_q     <= 1'b0;
         bounce_q   <= 1'b0;
         ball_on_q  <= 1'b0;
         lost_cnt_q <= 6'd0;
      end else begin
         state_q    <= state_d;
         ball_x_q   <= ball_x_d;
         ball_y_q   <= ball_y_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         lose_q     <= lose_d;
         bounce_q   <= bounce_d;
         ball_on_q  <= ball_on_d;
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign ball_x  = ball_x_q;
   assign ball_y  = ball_y_q;
   assign ball_on = ball_on_q;
   assign lose    = lose_q;
   assign bounce  = bounce_q;
   assign state   = state_q;
endmodule
